// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between ICACHE line refills
// (8-beat INCR bursts) and LSU single-word loads; one transaction in flight at a time.
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int AXI_ID_WIDTH = 4,
    parameter int LINE_BEATS   = 8,
    parameter int LINE_WIDTH   = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ic_req_valid,
    input  logic [ADDR_WIDTH-1:0]   ic_req_addr,
    output logic                    ic_req_ready,
    output logic                    ic_resp_valid,
    output logic [LINE_WIDTH-1:0]   ic_resp_data,
    output logic                    ic_resp_err,
    input  logic                    lsu_req_valid,
    input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
    output logic                    lsu_req_ready,
    output logic                    lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_resp_data,
    output logic                    lsu_resp_err,
    output logic [AXI_ID_WIDTH-1:0] m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [AXI_ID_WIDTH-1:0] m_rid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready
);
    localparam int LINE_OFF = $clog2(LINE_WIDTH / 8);
    localparam int WORD_OFF = $clog2(DATA_WIDTH / 8);
    localparam int CNT_W    = $clog2(LINE_BEATS);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;          // 0 = ICACHE, 1 = LSU
    logic                    last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    err_q, err_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;

    logic ic_win, lsu_win, grant_ok;
    logic unused_bits;

    assign unused_bits = ^{m_rid, ic_req_addr[LINE_OFF-1:0], lsu_req_addr[WORD_OFF-1:0]};

    // ICACHE wins a tie unless it was granted last.
    assign ic_win   = ic_req_valid && (!lsu_req_valid || last_grant_q);
    assign lsu_win  = lsu_req_valid && !ic_win;
    assign grant_ok = (state_q == S_IDLE) && !rst;

    assign ic_req_ready  = grant_ok && ic_win;
    assign lsu_req_ready = grant_ok && lsu_win;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;
        line_d       = line_q;
        case (state_q)
            S_IDLE: begin
                if (ic_win || lsu_win) begin
                    owner_d      = lsu_win;
                    last_grant_d = lsu_win;
                    if (lsu_win) begin
                        araddr_d = {lsu_req_addr[ADDR_WIDTH-1:WORD_OFF], {WORD_OFF{1'b0}}};
                        arlen_d  = 8'd0;
                    end else begin
                        araddr_d = {ic_req_addr[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
                        arlen_d  = 8'(LINE_BEATS - 1);
                    end
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (m_arready) begin
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = S_R;
                end
            end
            S_R: begin
                if (m_rvalid) begin
                    line_d[int'(beat_cnt_q) * DATA_WIDTH +: DATA_WIDTH] = m_rdata;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    // A misplaced or missing rlast flags the response but only rlast ends the burst.
                    if ((m_rresp != 2'b00) || (m_rlast != (beat_cnt_q == arlen_q[CNT_W-1:0])))
                        err_d = 1'b1;
                    if (m_rlast)
                        state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            araddr_q     <= '0;
            arlen_q      <= '0;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
            line_q       <= line_d;
        end
    end

    assign m_arid    = AXI_ID_WIDTH'(owner_q);
    assign m_araddr  = araddr_q;
    assign m_arlen   = arlen_q;
    assign m_arsize  = 3'b010;
    assign m_arburst = 2'b01;
    assign m_arvalid = (state_q == S_AR);
    assign m_rready  = (state_q == S_R);

    assign ic_resp_valid  = (state_q == S_RESP) && !owner_q;
    assign lsu_resp_valid = (state_q == S_RESP) && owner_q;
    assign ic_resp_err    = ic_resp_valid && err_q;
    assign lsu_resp_err   = lsu_resp_valid && err_q;
    assign ic_resp_data   = line_q;
    assign lsu_resp_data  = line_q[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: the bench plays both requesters and the AXI slave.
module tb_axi_rd_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         ic_req_valid, ic_req_ready, ic_resp_valid, ic_resp_err;
    logic [31:0]  ic_req_addr;
    logic [255:0] ic_resp_data;
    logic         lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_resp_err;
    logic [31:0]  lsu_req_addr, lsu_resp_data;
    logic [3:0]   m_arid, m_rid;
    logic [31:0]  m_araddr, m_rdata;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;
    logic [1:0]   m_arburst, m_rresp;
    logic         m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_err(ic_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_ready(lsu_req_ready),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with requests already driven; returns just after the granting negedge.
    task automatic wait_ready(output bit got_ic, output bit got_lsu);
        bit seen = 1'b0;
        got_ic  = 1'b0;
        got_lsu = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            #1;
            if (ic_req_ready || lsu_req_ready) begin
                seen    = 1'b1;
                got_ic  = ic_req_ready;
                got_lsu = lsu_req_ready;
            end else begin
                @(negedge clk);
            end
        end
        check("grant_seen", seen, 1'b1);
    endtask

    // Slave side of one read: optional AR stall, data base+k, optional SLVERR beat, optional late rlast.
    task automatic serve(input logic [31:0] base, input int stall, input int err_beat, input bit bad_last,
                         output int t_resp, output logic [3:0] id, output logic [31:0] addr,
                         output logic [7:0] len);
        int guard = 0;
        int n;
        while (!m_arvalid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("arvalid_seen", m_arvalid, 1'b1);
        id   = m_arid;
        addr = m_araddr;
        len  = m_arlen;
        for (int s = 0; s < stall; s++) begin
            m_arready = 1'b0;
            @(negedge clk);
            check("ar_stable", {m_arvalid, m_arid, m_araddr, m_arlen}, {1'b1, id, addr, len});
        end
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        n = int'(len) + 1 + int'(bad_last);
        for (int k = 0; k < n; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = base + k;
            m_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            m_rlast  = bad_last ? (k == n - 1) : (k == int'(len));
            check("rready", m_rready, 1'b1);
            @(negedge clk);
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
        t_resp   = cyc_cnt;
    endtask

    initial begin
        bit          gi, gl;
        int          t0, tr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;

        rst = 1'b1;
        ic_req_valid = 1'b1; ic_req_addr = 32'h0;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h0;
        m_arready = 1'b0; m_rid = 4'h0; m_rdata = 32'h0; m_rresp = 2'b00;
        m_rlast = 1'b0; m_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", {ic_req_ready, lsu_req_ready}, 2'b00);
        check("rst_ar", {m_arvalid, m_arid, m_araddr, m_arlen}, 45'h0);
        check("rst_size_burst", {m_arsize, m_arburst}, 5'b010_01);
        check("rst_resp", {ic_resp_valid, ic_resp_err, lsu_resp_valid, lsu_resp_err, m_rready}, 5'b0);
        check("rst_data", {ic_resp_data, lsu_resp_data}, 288'h0);

        // Both requesters valid continuously from reset: ICACHE, LSU, ICACHE.
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            wait_ready(gi, gl);
            check("rr_grant", {gi, gl}, (g % 2 == 0) ? 2'b10 : 2'b01);
            @(negedge clk);
            if (g == 2) begin
                ic_req_valid  = 1'b0;
                lsu_req_valid = 1'b0;
            end
            serve(32'hA00, 0, -1, 1'b0, tr, id, addr, len);
            check("rr_resp", {ic_resp_valid, lsu_resp_valid}, (g % 2 == 0) ? 2'b10 : 2'b01);
            check("rr_wait", {ic_req_ready, lsu_req_ready}, 2'b00);
            check("rr_word", lsu_resp_data, 32'hA00);
            @(negedge clk);
            check("rr_single_pulse", {ic_resp_valid, lsu_resp_valid}, 2'b00);
        end

        // ICACHE only, unaligned miss address.
        ic_req_valid = 1'b1; ic_req_addr = 32'h0000_1234;
        wait_ready(gi, gl);
        t0 = cyc_cnt;
        check("ic_grant", {gi, gl}, 2'b10);
        @(negedge clk);
        ic_req_valid = 1'b0;
        serve(32'h100, 0, -1, 1'b0, tr, id, addr, len);
        check("ic_ar", {id, addr, len}, {4'd0, 32'h0000_1220, 8'd7});
        check("ic_latency", tr - t0, 10);
        check("ic_resp", {ic_resp_valid, ic_resp_err, lsu_resp_valid}, 3'b100);
        check("ic_line", ic_resp_data,
              256'h00000107_00000106_00000105_00000104_00000103_00000102_00000101_00000100);
        @(negedge clk);
        check("ic_pulse_end", ic_resp_valid, 1'b0);

        // LSU only, unaligned load address.
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_2003;
        wait_ready(gi, gl);
        t0 = cyc_cnt;
        check("lsu_grant", {gi, gl}, 2'b01);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        serve(32'hDEAD_BEEF, 0, -1, 1'b0, tr, id, addr, len);
        check("lsu_ar", {id, addr, len}, {4'd1, 32'h0000_2000, 8'd0});
        check("lsu_latency", tr - t0, 3);
        check("lsu_resp", {lsu_resp_valid, lsu_resp_err, ic_resp_valid}, 3'b100);
        check("lsu_word", lsu_resp_data, 32'hDEAD_BEEF);

        // AR stalled for 5 cycles delays the line by exactly 5.
        @(negedge clk);
        ic_req_valid = 1'b1; ic_req_addr = 32'h0000_0047;
        wait_ready(gi, gl);
        t0 = cyc_cnt;
        @(negedge clk);
        ic_req_valid = 1'b0;
        serve(32'h200, 5, -1, 1'b0, tr, id, addr, len);
        check("stall_ar", {id, addr, len}, {4'd0, 32'h0000_0040, 8'd7});
        check("stall_latency", tr - t0, 15);
        check("stall_resp", {ic_resp_valid, ic_resp_err}, 2'b10);
        check("stall_last_beat", ic_resp_data[255:224], 32'h207);

        // SLVERR on beat 3 of a line.
        @(negedge clk);
        ic_req_valid = 1'b1; ic_req_addr = 32'h0000_0080;
        wait_ready(gi, gl);
        @(negedge clk);
        ic_req_valid = 1'b0;
        serve(32'h300, 0, 3, 1'b0, tr, id, addr, len);
        check("slverr_resp", {ic_resp_valid, ic_resp_err}, 2'b11);

        // LSU read whose only beat lacks rlast; rlast arrives one beat late.
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0044;
        wait_ready(gi, gl);
        check("badlast_grant", {gi, gl}, 2'b01);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        serve(32'h55, 0, -1, 1'b1, tr, id, addr, len);
        check("badlast_resp", {lsu_resp_valid, lsu_resp_err, ic_resp_valid}, 3'b110);
        @(negedge clk);
        check("badlast_idle", {lsu_resp_valid, m_arvalid, m_rready}, 3'b000);

        // Reset in the middle of a line refill after 4 beats.
        ic_req_valid = 1'b1; ic_req_addr = 32'h0000_0600;
        wait_ready(gi, gl);
        check("midrst_grant", {gi, gl}, 2'b10);
        @(negedge clk);
        ic_req_valid = 1'b0;
        check("midrst_arvalid", m_arvalid, 1'b1);
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_rvalid = 1'b1; m_rdata = 32'h700 + k; m_rlast = 1'b0;
            @(negedge clk);
        end
        check("midrst_in_r", m_rready, 1'b1);
        rst = 1'b1;
        m_rvalid = 1'b0;
        @(negedge clk);
        check("midrst_idle", {m_rready, m_arvalid, ic_resp_valid, lsu_resp_valid}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_no_pulse", {m_rready, ic_resp_valid, lsu_resp_valid}, 3'b000);
        check("midrst_cleared", ic_resp_data, 256'h0);

        lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_3008;
        wait_ready(gi, gl);
        t0 = cyc_cnt;
        check("post_rst_grant", {gi, gl}, 2'b01);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        serve(32'h1234_5678, 0, -1, 1'b0, tr, id, addr, len);
        check("post_rst_ar", {id, addr, len}, {4'd1, 32'h0000_3008, 8'd0});
        check("post_rst_latency", tr - t0, 3);
        check("post_rst_resp", {lsu_resp_valid, lsu_resp_err}, 2'b10);
        check("post_rst_word", lsu_resp_data, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI4 read channel (AR/R) between two requesters: the ICACHE line-refill port and the LSU single-word load port.
- Arbitrates between them round-robin and issues the AXI read: an 8-beat INCR burst for ICACHE, a single beat for LSU.
- Collects the R beats and returns either a full 256-bit line (ICACHE) or one 32-bit word (LSU), with an error flag.
- Sits between the ICACHE/LSU and the AXI memory slave.

Parameters:
- ADDR_WIDTH, 32, request/AXI address width.
- DATA_WIDTH, 32, AXI data width and LSU word width.
- AXI_ID_WIDTH, 4, ARID/RID width.
- LINE_BEATS, 8, words per ICACHE line (2**ICACHE_LINE_OFFSET).
- LINE_WIDTH, 256, ICACHE line data width (LINE_BEATS*DATA_WIDTH).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ic_req_valid  in  1  ICACHE refill request; held until ic_req_ready.
- ic_req_addr  in  ADDR_WIDTH  miss address (any alignment).
- ic_req_ready  out  1  one-cycle pulse: ICACHE request accepted.
- ic_resp_valid  out  1  one-cycle pulse: line returned.
- ic_resp_data  out  LINE_WIDTH  line; beat k lands at bits [32k+31:32k].
- ic_resp_err  out  1  valid with ic_resp_valid.
- lsu_req_valid  in  1  LSU load request; held until lsu_req_ready.
- lsu_req_addr  in  ADDR_WIDTH  load address.
- lsu_req_ready  out  1  one-cycle pulse: LSU request accepted.
- lsu_resp_valid  out  1  one-cycle pulse: word returned.
- lsu_resp_data  out  DATA_WIDTH  word read.
- lsu_resp_err  out  1  valid with lsu_resp_valid.
- m_arid  out  AXI_ID_WIDTH  0 = ICACHE, 1 = LSU.
- m_araddr  out  ADDR_WIDTH  burst start address.
- m_arlen  out  8  7 for ICACHE, 0 for LSU.
- m_arsize  out  3  always AXI_SIZE_4B (3'b010).
- m_arburst  out  2  always AXI_BURST_INCR (2'b01).
- m_arvalid  out  1  AR valid.
- m_arready  in  1  AR ready.
- m_rid  in  AXI_ID_WIDTH  R id (ignored; one outstanding transaction).
- m_rdata  in  DATA_WIDTH  R data.
- m_rresp  in  2  R response.
- m_rlast  in  1  last beat.
- m_rvalid  in  1  R valid.
- m_rready  out  1  R ready.

Behaviour:
- Reset: state IDLE; all outputs 0 except m_arsize=3'b010 and m_arburst=2'b01; response data regs cleared; last_grant=LSU, so ICACHE wins the first tie.
- FSM states: IDLE, AR, R, RESP.
- IDLE, request pending: grant per round-robin.
  - Only one valid: grant it.
  - Both valid: grant the one that is not last_grant.
  - Pulse that requester's req_ready this cycle; latch owner, address and length; update last_grant; go to AR.
- Address formation:
  - ICACHE: m_araddr = {addr[31:5], 5'b0}, m_arlen=7.
  - LSU: m_araddr = {addr[31:2], 2'b0}, m_arlen=0.
- AR: m_arvalid=1 with stable AR fields until m_arready. On the handshake cycle go to R and clear the beat counter and err.
- R: m_rready=1.
  - On each beat (m_rvalid & m_rready): store m_rdata in slot beat_cnt; increment beat_cnt (3-bit).
  - err |= (m_rresp != 2'b00).
  - err |= rlast mismatch: m_rlast asserted when beat_cnt != arlen, or m_rlast absent on beat arlen.
  - On the beat with m_rlast=1: go to RESP.
  - A missing rlast does not end the burst: keep accepting beats until rlast; beat_cnt wraps, and later beats overwrite slots mod 8.
- RESP: pulse the owner's resp_valid for exactly 1 cycle with data/err; the other requester's resp_valid stays 0; return to IDLE. No backpressure on responses.
- Latency, with arready and rvalid always high and request accepted in cycle T:
  - m_arvalid at T+1.
  - Beats at T+2..T+2+arlen.
  - resp_valid at T+3+arlen: T+10 for ICACHE, T+3 for LSU.
- Requests arriving in AR/R/RESP wait with ready=0. A new grant is possible in the cycle after RESP.
- m_rvalid outside R is ignored (m_rready=0).
- Reset mid-operation forces IDLE and drops the transaction; the slave is assumed reset alongside.
- Only one transaction is ever outstanding.

Test Plan:
- ICACHE only, ic_req_addr=0x0000_1234, slave returns 0x100..0x107 with arready/rvalid high:
  - araddr=0x0000_1220, arlen=7, arid=0.
  - ic_resp_valid at T+10, ic_resp_data[31:0]=0x100, [255:224]=0x107, err=0.
- LSU only, addr=0x0000_2003, rdata=0xDEAD_BEEF:
  - araddr=0x0000_2000, arlen=0, arid=1.
  - lsu_resp_valid at T+3 with 0xDEAD_BEEF, err=0.
- Both valid continuously from reset: grants go ICACHE, LSU, ICACHE, with no missed or duplicated resp pulses.
- m_arready held low for 5 cycles: m_arvalid and all AR fields stay stable; the response is delayed by exactly 5 cycles.
- ICACHE burst with beat 3 rresp=SLVERR, and separately an LSU read with rlast=0: ic_resp_err=1 and lsu_resp_err=1 respectively; the FSM returns to IDLE.
- rst asserted in R after 4 beats:
  - Next cycle: state IDLE, m_rready=0, no resp pulse.
  - A subsequent LSU read completes normally.
